// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data RAM between the CPU MEM stage and the AUX
// loader/debug port. One access is granted per cycle. The CPU has priority,
// but after STARVE_MAX consecutive CPU wins while AUX waits, AUX is forced
// through. Read data comes back one cycle after issue and is routed to the
// requester that issued the read.
//
// Parameters
//   AW          word-address width of the data RAM
//   DW          data width
//   STARVE_MAX  consecutive CPU wins tolerated while AUX waits (1..15)
//
// Ports
//   CLK, RESET                     clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          CPU request (held while cpu_stall=1)
//   cpu_stall                      CPU lost arbitration this cycle
//   cpu_rvalid/cpu_rdata           CPU read return (rdata=0 when not valid)
//   aux_req/we/addr/wdata          AUX request (held until aux_gnt)
//   aux_gnt                        AUX access issued this cycle
//   aux_rvalid/aux_rdata           AUX read return (rdata=0 when not valid)
//   ram_en/we/addr/wdata           RAM command (all 0 when idle)
//   ram_rdata                      RAM read data, valid 1 cycle after issue
//   stat_cpu_gnt/stat_aux_gnt/stat_stall
//                                  saturating event counters, present only
//                                  when ARB_STATS_EN is defined
//
// Handshake: a request is a "valid" that must stay asserted with stable
// payload until accepted. The CPU side is accepted in any cycle where
// cpu_req=1 and cpu_stall=0; the AUX side is accepted in any cycle where
// aux_gnt=1. An accepted read returns exactly one cycle later as a
// single-cycle rvalid pulse; there is no back-pressure on the return path.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int AW         = 10,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_stall,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          aux_req,
   input  logic          aux_we,
   input  logic [AW-1:0] aux_addr,
   input  logic [DW-1:0] aux_wdata,
   output logic          aux_gnt,
   output logic          aux_rvalid,
   output logic [DW-1:0] aux_rdata,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]   stat_cpu_gnt,
   output logic [31:0]   stat_aux_gnt,
   output logic [31:0]   stat_stall
`endif
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   localparam logic       OWN_CPU    = 1'b0;
   localparam logic       OWN_AUX    = 1'b1;

   logic [3:0] starve_cnt;
   logic       rd_pend;
   logic       rd_owner;
   logic       aux_forced;
   logic       cpu_won;
   logic       aux_won;
   logic       rd_issue;

   // ---------------------------------------------------------------------------
   // Grant. Everything is gated by RESET so no command leaks out while the
   // requesters may still be asserting stale requests.
   // ---------------------------------------------------------------------------
   assign aux_forced = cpu_req & aux_req & (starve_cnt == STARVE_LIM);
   assign cpu_won    = ~RESET & cpu_req & ~aux_forced;
   assign aux_won    = ~RESET & aux_req & (~cpu_req | aux_forced);

   assign cpu_stall  = ~RESET & cpu_req & ~cpu_won;
   assign aux_gnt    = aux_won;

   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (cpu_won) begin
         ram_en    = 1'b1;
         ram_we    = cpu_we;
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
      end else if (aux_won) begin
         ram_en    = 1'b1;
         ram_we    = aux_we;
         ram_addr  = aux_addr;
         ram_wdata = aux_wdata;
      end
   end

   assign rd_issue = ram_en & ~ram_we;

   // ---------------------------------------------------------------------------
   // Starvation counter: counts CPU wins only while AUX is actually waiting.
   // Any cycle where AUX is idle or gets through restarts the count.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         starve_cnt <= '0;
      end else if (aux_won || !aux_req) begin
         starve_cnt <= '0;
      end else if (cpu_won) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Read return tracking. Only one read can be outstanding because the RAM
   // latency is one cycle, so a single owner bit is enough to keep
   // alternating-owner reads in issue order.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rd_pend  <= 1'b0;
         rd_owner <= OWN_CPU;
      end else begin
         rd_pend <= rd_issue;
         if (rd_issue) begin
            rd_owner <= aux_won ? OWN_AUX : OWN_CPU;
         end
      end
   end

   // Gating with RESET drops a return whose read was issued in the cycle just
   // before reset went high.
   assign cpu_rvalid = ~RESET & rd_pend & (rd_owner == OWN_CPU);
   assign aux_rvalid = ~RESET & rd_pend & (rd_owner == OWN_AUX);
   assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
   assign aux_rdata  = aux_rvalid ? ram_rdata : '0;

`ifdef ARB_STATS_EN
   // ---------------------------------------------------------------------------
   // Saturating event counters.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         stat_cpu_gnt <= '0;
         stat_aux_gnt <= '0;
         stat_stall   <= '0;
      end else begin
         if (cpu_won && (stat_cpu_gnt != 32'hFFFF_FFFF)) begin
            stat_cpu_gnt <= stat_cpu_gnt + 32'd1;
         end
         if (aux_won && (stat_aux_gnt != 32'hFFFF_FFFF)) begin
            stat_aux_gnt <= stat_aux_gnt + 32'd1;
         end
         if (cpu_stall && (stat_stall != 32'hFFFF_FFFF)) begin
            stat_stall <= stat_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter: a directed table of per-cycle vectors followed by
// randomized traffic. A behavioural model tracks how many times in a row AUX
// has been passed over, the single outstanding read, and a shadow copy of
// the RAM contents. Build with +define+ARB_STATS_EN to also check the
// statistics counters.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int AW         = 10;
   localparam int DW         = 32;
   localparam int STARVE_MAX = 4;
   localparam int N_RAND     = 400;

   // ------------------------------------------------------------------ clock/reset
   logic          CLK = 1'b0;
   logic          RESET;
   always #5 CLK = ~CLK;

   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_stall, cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          aux_req, aux_we;
   logic [AW-1:0] aux_addr;
   logic [DW-1:0] aux_wdata;
   logic          aux_gnt, aux_rvalid;
   logic [DW-1:0] aux_rdata;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
`ifdef ARB_STATS_EN
   logic [31:0]   stat_cpu_gnt, stat_aux_gnt, stat_stall;
`endif

   dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
      .CLK(CLK), .RESET(RESET),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
      .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
`ifdef ARB_STATS_EN
      ,
      .stat_cpu_gnt(stat_cpu_gnt), .stat_aux_gnt(stat_aux_gnt), .stat_stall(stat_stall)
`endif
   );

   // ------------------------------------------------------------------ RAM
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge CLK) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   // ------------------------------------------------------------------ vectors
   typedef struct {
      logic          rst;
      logic          creq;
      logic          cwe;
      logic [AW-1:0] caddr;
      logic [DW-1:0] cwd;
      logic          areq;
      logic          awe;
      logic [AW-1:0] aaddr;
      logic [DW-1:0] awd;
      logic          e_stall;
      logic          e_gnt;
      logic          e_en;
      logic [AW-1:0] e_addr;
      logic          e_crv;
      logic [DW-1:0] e_crd;
      logic          e_arv;
      logic [DW-1:0] e_ard;
   } vec_t;

   function automatic vec_t mk(
      input logic rst, input logic creq, input logic cwe, input logic [AW-1:0] caddr,
      input logic [DW-1:0] cwd, input logic areq, input logic awe,
      input logic [AW-1:0] aaddr, input logic [DW-1:0] awd,
      input logic e_stall, input logic e_gnt, input logic e_en, input logic [AW-1:0] e_addr,
      input logic e_crv, input logic [DW-1:0] e_crd, input logic e_arv,
      input logic [DW-1:0] e_ard);
      vec_t v;
      v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
      v.areq = areq; v.awe = awe; v.aaddr = aaddr; v.awd = awd;
      v.e_stall = e_stall; v.e_gnt = e_gnt; v.e_en = e_en; v.e_addr = e_addr;
      v.e_crv = e_crv; v.e_crd = e_crd; v.e_arv = e_arv; v.e_ard = e_ard;
      return v;
   endfunction

   // ------------------------------------------------------------------ scoreboard
   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle=%0d act=%h exp=%h", name, cyc, act, exp);
      end
   endtask

   // ------------------------------------------------------------------ reference model
   // m_passed: how many grants in a row the CPU has taken while AUX waited.
   // m_pend:   0 none, 1 CPU read outstanding, 2 AUX read outstanding.
   logic [DW-1:0] exp_mem [0:(1<<AW)-1];
   int            m_passed = 0;
   int            m_pend   = 0;
   logic [DW-1:0] m_data   = '0;
   bit            m_cw, m_aw;
   int            m_ncg = 0, m_nag = 0, m_nst = 0;

   // ------------------------------------------------------------------ driver
   task automatic run_cycle(input vec_t v, input bit use_tab);
      bit            forced, exp_stall, exp_crv, exp_arv;
      logic          exp_we;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wd;
      RESET     = v.rst;
      cpu_req   = v.creq;  cpu_we = v.cwe;  cpu_addr = v.caddr;  cpu_wdata = v.cwd;
      aux_req   = v.areq;  aux_we = v.awe;  aux_addr = v.aaddr;  aux_wdata = v.awd;
      @(negedge CLK);

      forced    = v.creq && v.areq && (m_passed == STARVE_MAX);
      m_cw      = !v.rst && v.creq && !forced;
      m_aw      = !v.rst && v.areq && (!v.creq || forced);
      exp_stall = !v.rst && v.creq && !m_cw;
      exp_crv   = !v.rst && (m_pend == 1);
      exp_arv   = !v.rst && (m_pend == 2);
      exp_we    = m_cw ? v.cwe   : (m_aw ? v.awe   : 1'b0);
      exp_addr  = m_cw ? v.caddr : (m_aw ? v.aaddr : '0);
      exp_wd    = m_cw ? v.cwd   : (m_aw ? v.awd   : '0);

      chk("cpu_stall",  32'(cpu_stall),  32'(exp_stall));
      chk("aux_gnt",    32'(aux_gnt),    32'(m_aw));
      chk("ram_en",     32'(ram_en),     32'(m_cw || m_aw));
      chk("ram_we",     32'(ram_we),     32'(exp_we));
      chk("ram_addr",   32'(ram_addr),   32'(exp_addr));
      chk("ram_wdata",  ram_wdata,       exp_wd);
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_crv));
      chk("cpu_rdata",  cpu_rdata,       exp_crv ? m_data : 32'h0);
      chk("aux_rvalid", 32'(aux_rvalid), 32'(exp_arv));
      chk("aux_rdata",  aux_rdata,       exp_arv ? m_data : 32'h0);

      if (use_tab) begin
         chk("tab_stall",  32'(cpu_stall),  32'(v.e_stall));
         chk("tab_gnt",    32'(aux_gnt),    32'(v.e_gnt));
         chk("tab_en",     32'(ram_en),     32'(v.e_en));
         chk("tab_addr",   32'(ram_addr),   32'(v.e_addr));
         chk("tab_crv",    32'(cpu_rvalid), 32'(v.e_crv));
         chk("tab_crd",    cpu_rdata,       v.e_crd);
         chk("tab_arv",    32'(aux_rvalid), 32'(v.e_arv));
         chk("tab_ard",    aux_rdata,       v.e_ard);
      end

      @(posedge CLK);
      if (v.rst) begin
         m_passed = 0;
         m_pend   = 0;
         m_ncg = 0; m_nag = 0; m_nst = 0;
      end else begin
         if (m_aw || !v.areq)     m_passed = 0;
         else if (m_cw)           m_passed++;
         m_pend = 0;
         if ((m_cw || m_aw) && !exp_we) begin
            m_pend = m_cw ? 1 : 2;
            m_data = exp_mem[exp_addr];
         end
         if ((m_cw || m_aw) && exp_we) exp_mem[exp_addr] = exp_wd;
         if (m_cw)      m_ncg++;
         if (m_aw)      m_nag++;
         if (exp_stall) m_nst++;
      end
      cyc++;
      #1;
   endtask

   // ------------------------------------------------------------------ test
   vec_t tab [24];
   vec_t cur;

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i]     = '0;
         exp_mem[i] = '0;
      end
      mem[4]     = 32'hDEAD_BEEF;
      exp_mem[4] = 32'hDEAD_BEEF;

      // Reset held with both requesting, then two quiet cycles.
      for (int i = 0; i < 3; i++) tab[i] = mk(1,1,0,0,0,1,0,0,0, 0,0,0,0,0,0,0,0);
      tab[3] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
      tab[4] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
      // CPU read of word 4, returns next cycle.
      tab[5] = mk(0,1,0,10'h004,0,0,0,0,0, 0,0,1,10'h004,0,0,0,0);
      tab[6] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,1,32'hDEAD_BEEF,0,0);
      // Both requesting for 10 cycles: C,C,C,C,A,C,C,C,C,A.
      for (int i = 0; i < 10; i++) begin
         if (i == 4 || i == 9)
            tab[7+i] = mk(0,1,1,10'h020,32'h1,1,1,10'h030,32'h2, 1,1,1,10'h030,0,0,0,0);
         else
            tab[7+i] = mk(0,1,1,10'h020,32'h1,1,1,10'h030,32'h2, 0,0,1,10'h020,0,0,0,0);
      end
      // AUX write then CPU read of the same word.
      tab[17] = mk(0,0,0,0,0,1,1,10'h010,32'hAA, 0,1,1,10'h010,0,0,0,0);
      tab[18] = mk(0,1,0,10'h010,0,0,0,0,0, 0,0,1,10'h010,0,0,0,0);
      tab[19] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,1,32'hAA,0,0);
      // AUX read interrupted by reset: no return.
      tab[20] = mk(0,0,0,0,0,1,0,10'h004,0, 0,1,1,10'h004,0,0,0,0);
      tab[21] = mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
      tab[22] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
      tab[23] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);

      for (int i = 0; i < 24; i++) run_cycle(tab[i], 1'b1);

      // Randomized traffic; stalled/ungranted requests are held stable.
      cur = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
      for (int n = 0; n < N_RAND; n++) begin
         bit hold_c, hold_a;
         hold_c = !cur.rst && cur.creq && !m_cw;
         hold_a = !cur.rst && cur.areq && !m_aw;
         cur.rst = ($urandom_range(0, 39) == 0);
         if (!hold_c) begin
            cur.creq  = ($urandom_range(0, 9) < 6);
            cur.cwe   = $urandom_range(0, 1);
            cur.caddr = AW'($urandom_range(0, 15));
            cur.cwd   = $urandom;
         end
         if (!hold_a) begin
            cur.areq  = ($urandom_range(0, 9) < 5);
            cur.awe   = $urandom_range(0, 1);
            cur.aaddr = AW'($urandom_range(0, 15));
            cur.awd   = $urandom;
         end
         run_cycle(cur, 1'b0);
      end

`ifdef ARB_STATS_EN
      chk("stat_cpu_gnt", stat_cpu_gnt, 32'(m_ncg));
      chk("stat_aux_gnt", stat_aux_gnt, 32'(m_nag));
      chk("stat_stall",   stat_stall,   32'(m_nst));
      // Reset, then six cycles of contention: C,C,C,C,A,C.
      run_cycle(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0), 1'b0);
      for (int i = 0; i < 6; i++)
         run_cycle(mk(0,1,1,10'h020,32'h1,1,1,10'h030,32'h2, 0,0,0,0,0,0,0,0), 1'b0);
      chk("stat_cpu_gnt_6", stat_cpu_gnt, 32'd5);
      chk("stat_aux_gnt_6", stat_aux_gnt, 32'd1);
      chk("stat_stall_6",   stat_stall,   32'd1);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
